operand_fetch_stage: RTL and testbench

//  ID stage of the pipelined RISC16 core; sits between the IF/ID latch and the EX stage.

---
 rtl/operand_fetch_stage_pkg.sv | 87 ++++++++
 rtl/operand_fwd_mux.sv | 38 +++
 rtl/operand_fetch_stage.sv | 123 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared RISC16 definitions for the operand-fetch (ID) stage: opcode
// encoding, instruction field positions and the instruction decoder.
package operand_fetch_stage_pkg;

    localparam int WORD_LEN     = 16;
    localparam int REG_ADDR_LEN = 3;

    // Instruction field positions (LSB of each field)
    localparam int OP_LSB = 13;
    localparam int RA_LSB = 10;
    localparam int RB_LSB = 7;
    localparam int RC_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_e;

    typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;
    typedef logic [WORD_LEN-1:0]     word_t;

    // Decoded instruction. A source that the instruction does not read is 0,
    // so it can never match a non-zero producer target.
    typedef struct packed {
        opcode_e   opcode;
        reg_addr_t src1;
        reg_addr_t src2;
        reg_addr_t tgt;
        logic      wr_en;
        word_t     imm;
    } decode_t;

    function automatic word_t sext7(input logic [6:0] imm7);
        return {{(WORD_LEN-7){imm7[6]}}, imm7};
    endfunction

    function automatic decode_t decode_instr(input word_t instr);
        decode_t   d;
        reg_addr_t ra;
        reg_addr_t rb;
        reg_addr_t rc;
        d        = '0;
        ra       = instr[RA_LSB +: REG_ADDR_LEN];
        rb       = instr[RB_LSB +: REG_ADDR_LEN];
        rc       = instr[RC_LSB +: REG_ADDR_LEN];
        d.opcode = opcode_e'(instr[OP_LSB +: 3]);
        case (d.opcode)
            OP_ADD, OP_NAND: begin
                d.src1  = rb;
                d.src2  = rc;
                d.tgt   = ra;
                d.wr_en = 1'b1;
            end
            OP_ADDI, OP_LW, OP_JALR: begin
                d.src1  = rb;
                d.tgt   = ra;
                d.wr_en = 1'b1;
                d.imm   = sext7(instr[6:0]);
            end
            OP_SW: begin
                d.src1 = rb;
                d.src2 = ra;
                d.imm  = sext7(instr[6:0]);
            end
            OP_BEQ: begin
                d.src1 = ra;
                d.src2 = rb;
                d.imm  = sext7(instr[6:0]);
            end
            OP_LUI: begin
                d.tgt   = ra;
                d.wr_en = 1'b1;
                d.imm   = {instr[9:0], 6'b0};
            end
        endcase
        // Writes to r0 are architecturally discarded.
        d.wr_en = d.wr_en && (d.tgt != '0);
        return d;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Four-way priority bypass for one operand: EX > MEM > WB > register file.
// r0 always reads as zero regardless of any producer.
module operand_fwd_mux #(
    parameter int p_WORD_LEN     = 16,
    parameter int p_REG_ADDR_LEN = 3
) (
    input  logic [p_REG_ADDR_LEN-1:0] i_src,
    input  logic [p_WORD_LEN-1:0]     i_rf_data,
    input  logic                      i_ex_en,
    input  logic [p_REG_ADDR_LEN-1:0] i_ex_tgt,
    input  logic [p_WORD_LEN-1:0]     i_ex_data,
    input  logic                      i_mem_en,
    input  logic [p_REG_ADDR_LEN-1:0] i_mem_tgt,
    input  logic [p_WORD_LEN-1:0]     i_mem_data,
    input  logic                      i_wb_en,
    input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
    input  logic [p_WORD_LEN-1:0]     i_wb_data,
    output logic [p_WORD_LEN-1:0]     o_data
);

    // Select the youngest in-flight producer of i_src, else the regfile value.
    always_comb begin
        // NOTE: default first so every path assigns o_data and no latch is inferred.
        o_data = i_rf_data;
        if (i_src == '0) begin
            o_data = '0;
        end else if (i_ex_en && (i_ex_tgt == i_src)) begin
            o_data = i_ex_data;
        end else if (i_mem_en && (i_mem_tgt == i_src)) begin
            o_data = i_mem_data;
        end else if (i_wb_en && (i_wb_tgt == i_src)) begin
            // The regfile write lands on the same edge as the ID/EX capture,
            // so the regfile read here is still stale.
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// RISC16 ID stage: decodes the IF/ID instruction, drives regfile read
// addresses, resolves operands through the bypass network, detects load-use
// hazards and holds the ID/EX pipeline register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int p_WORD_LEN     = 16,
    parameter int p_REG_ADDR_LEN = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic [p_WORD_LEN-1:0]     i_instr,
    input  logic [p_WORD_LEN-1:0]     i_pc,
    input  logic                      i_flush,
    output logic                      o_stall,
    output logic [p_REG_ADDR_LEN-1:0] o_src1,
    output logic [p_REG_ADDR_LEN-1:0] o_src2,
    input  logic [p_WORD_LEN-1:0]     i_src1_data,
    input  logic [p_WORD_LEN-1:0]     i_src2_data,
    input  logic [p_REG_ADDR_LEN-1:0] i_ex_tgt,
    input  logic                      i_ex_wr_en,
    input  logic                      i_ex_is_ld,
    input  logic [p_WORD_LEN-1:0]     i_ex_result,
    input  logic [p_REG_ADDR_LEN-1:0] i_mem_tgt,
    input  logic                      i_mem_wr_en,
    input  logic [p_WORD_LEN-1:0]     i_mem_data,
    input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
    input  logic                      i_wb_wr_en,
    input  logic [p_WORD_LEN-1:0]     i_wb_data,
    output logic                      o_valid,
    output logic [2:0]                o_opcode,
    output logic [p_REG_ADDR_LEN-1:0] o_tgt,
    output logic                      o_wr_en,
    output logic [p_WORD_LEN-1:0]     o_op1,
    output logic [p_WORD_LEN-1:0]     o_op2,
    output logic [p_WORD_LEN-1:0]     o_imm,
    output logic [p_WORD_LEN-1:0]     o_pc
);

    decode_t               dec;
    logic                  ex_fwd_en;
    logic                  hazard;
    logic                  capture;
    logic [p_WORD_LEN-1:0] op1;
    logic [p_WORD_LEN-1:0] op2;

    assign dec    = decode_instr(i_instr);
    assign o_src1 = dec.src1;
    assign o_src2 = dec.src2;

    // A load's EX result is only an address, never the loaded data.
    assign ex_fwd_en = i_ex_wr_en && !i_ex_is_ld;

    operand_fwd_mux #(
        .p_WORD_LEN    (p_WORD_LEN),
        .p_REG_ADDR_LEN(p_REG_ADDR_LEN)
    ) u_fwd_op1 (
        .i_src     (dec.src1),
        .i_rf_data (i_src1_data),
        .i_ex_en   (ex_fwd_en),
        .i_ex_tgt  (i_ex_tgt),
        .i_ex_data (i_ex_result),
        .i_mem_en  (i_mem_wr_en),
        .i_mem_tgt (i_mem_tgt),
        .i_mem_data(i_mem_data),
        .i_wb_en   (i_wb_wr_en),
        .i_wb_tgt  (i_wb_tgt),
        .i_wb_data (i_wb_data),
        .o_data    (op1)
    );

    operand_fwd_mux #(
        .p_WORD_LEN    (p_WORD_LEN),
        .p_REG_ADDR_LEN(p_REG_ADDR_LEN)
    ) u_fwd_op2 (
        .i_src     (dec.src2),
        .i_rf_data (i_src2_data),
        .i_ex_en   (ex_fwd_en),
        .i_ex_tgt  (i_ex_tgt),
        .i_ex_data (i_ex_result),
        .i_mem_en  (i_mem_wr_en),
        .i_mem_tgt (i_mem_tgt),
        .i_mem_data(i_mem_data),
        .i_wb_en   (i_wb_wr_en),
        .i_wb_tgt  (i_wb_tgt),
        .i_wb_data (i_wb_data),
        .o_data    (op2)
    );

    // Load-use: unused sources decode to r0 and the load target is non-zero,
    // so comparing against both sources only ever hits a used one.
    assign hazard  = i_valid && !i_flush && i_ex_is_ld && i_ex_wr_en
                     && (i_ex_tgt != '0)
                     && ((i_ex_tgt == dec.src1) || (i_ex_tgt == dec.src2));
    assign o_stall = i_rst_n && hazard;
    assign capture = i_valid && !i_flush && !hazard;

    // ID/EX register: capture the resolved instruction or insert a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !capture) begin
            // NOTE: non-blocking assignments for all flops so every field samples pre-edge values.
            o_valid  <= 1'b0;
            o_opcode <= '0;
            o_tgt    <= '0;
            o_wr_en  <= 1'b0;
            o_op1    <= '0;
            o_op2    <= '0;
            o_imm    <= '0;
            o_pc     <= '0;
        end else begin
            o_valid  <= 1'b1;
            o_opcode <= dec.opcode;
            o_tgt    <= dec.tgt;
            o_wr_en  <= dec.wr_en;
            o_op1    <= op1;
            o_op2    <= op2;
            o_imm    <= dec.imm;
            o_pc     <= i_pc;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for the RISC16 ID stage: directed scenarios followed by
// randomized traffic, all predicted by an instruction-level reference model.
module tb_operand_fetch_stage;

    localparam logic [2:0] T_ADD  = 3'd0;
    localparam logic [2:0] T_ADDI = 3'd1;
    localparam logic [2:0] T_NAND = 3'd2;
    localparam logic [2:0] T_LUI  = 3'd3;
    localparam logic [2:0] T_SW   = 3'd4;
    localparam logic [2:0] T_LW   = 3'd5;
    localparam logic [2:0] T_BEQ  = 3'd6;

    typedef struct packed {
        logic        valid;
        logic [2:0]  opcode;
        logic [2:0]  tgt;
        logic        wr_en;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic [15:0] pc;
    } idex_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        flush;
    logic        stall;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [15:0] src1_data;
    logic [15:0] src2_data;
    logic [2:0]  ex_tgt;
    logic        ex_wr_en;
    logic        ex_is_ld;
    logic [15:0] ex_result;
    logic [2:0]  mem_tgt;
    logic        mem_wr_en;
    logic [15:0] mem_data;
    logic [2:0]  wb_tgt;
    logic        wb_wr_en;
    logic [15:0] wb_data;
    logic        o_valid;
    logic [2:0]  o_opcode;
    logic [2:0]  o_tgt;
    logic        o_wr_en;
    logic [15:0] o_op1;
    logic [15:0] o_op2;
    logic [15:0] o_imm;
    logic [15:0] o_pc;

    logic [15:0] rf [8];
    int          n_checks;
    int          n_fail;

    assign src1_data = rf[src1];
    assign src2_data = rf[src2];

    operand_fetch_stage #(
        .p_WORD_LEN    (16),
        .p_REG_ADDR_LEN(3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_instr    (instr),
        .i_pc       (pc),
        .i_flush    (flush),
        .o_stall    (stall),
        .o_src1     (src1),
        .o_src2     (src2),
        .i_src1_data(src1_data),
        .i_src2_data(src2_data),
        .i_ex_tgt   (ex_tgt),
        .i_ex_wr_en (ex_wr_en),
        .i_ex_is_ld (ex_is_ld),
        .i_ex_result(ex_result),
        .i_mem_tgt  (mem_tgt),
        .i_mem_wr_en(mem_wr_en),
        .i_mem_data (mem_data),
        .i_wb_tgt   (wb_tgt),
        .i_wb_wr_en (wb_wr_en),
        .i_wb_data  (wb_data),
        .o_valid    (o_valid),
        .o_opcode   (o_opcode),
        .o_tgt      (o_tgt),
        .o_wr_en    (o_wr_en),
        .o_op1      (o_op1),
        .o_op2      (o_op2),
        .o_imm      (o_imm),
        .o_pc       (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] rc);
        return {op, ra, rb, 4'b0, rc};
    endfunction

    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] imm7);
        return {op, ra, rb, imm7};
    endfunction

    // Architectural value register r will hold once every older instruction
    // retires: the youngest in-flight writer wins, loads in EX have no data yet.
    function automatic logic [15:0] reg_value(input logic [2:0] r);
        if (r == 3'd0) return 16'h0000;
        if (ex_wr_en && !ex_is_ld && ex_tgt == r) return ex_result;
        if (mem_wr_en && mem_tgt == r) return mem_data;
        if (wb_wr_en && wb_tgt == r) return wb_data;
        return rf[r];
    endfunction

    // Reference model: from the current inputs, predict read addresses, stall
    // and the ID/EX contents after the next edge.
    function automatic void predict(output logic [2:0] s1, output logic [2:0] s2,
                                    output logic stl, output idex_t e);
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rc;
        logic       writes;
        logic       hz;
        int         v;
        op = instr[15:13];
        ra = instr[12:10];
        rb = instr[9:7];
        rc = instr[2:0];
        s1 = (op == T_LUI) ? 3'd0 : (op == T_BEQ) ? ra : rb;
        s2 = (op == T_ADD || op == T_NAND) ? rc :
             (op == T_SW) ? ra : (op == T_BEQ) ? rb : 3'd0;
        writes = !(op == T_SW || op == T_BEQ);
        v = int'(instr[6:0]);
        if (v >= 64) v -= 128;
        hz  = valid && !flush && ex_is_ld && ex_wr_en && ex_tgt != 3'd0
              && (ex_tgt == s1 || ex_tgt == s2);
        stl = rst_n && hz;
        e   = '0;
        if (rst_n && valid && !flush && !hz) begin
            e.valid  = 1'b1;
            e.opcode = op;
            e.tgt    = writes ? ra : 3'd0;
            e.wr_en  = writes && ra != 3'd0;
            e.op1    = reg_value(s1);
            e.op2    = reg_value(s2);
            e.pc     = pc;
            if (op == T_LUI) e.imm = 16'(instr[9:0]) * 16'd64;
            else if (op == T_ADD || op == T_NAND) e.imm = 16'h0000;
            else e.imm = 16'(v);
        end
    endfunction

    // One clock: check combinational outputs, clock, check ID/EX, then let
    // the regfile model absorb the WB write that landed on that edge.
    task automatic step(input string tag);
        logic [2:0] es1;
        logic [2:0] es2;
        logic       estall;
        idex_t      e;
        #1;
        predict(es1, es2, estall, e);
        check({tag, "/src1"},  16'(src1),  16'(es1));
        check({tag, "/src2"},  16'(src2),  16'(es2));
        check({tag, "/stall"}, 16'(stall), 16'(estall));
        @(posedge clk);
        #1;
        check({tag, "/valid"},  16'(o_valid),  16'(e.valid));
        check({tag, "/opcode"}, 16'(o_opcode), 16'(e.opcode));
        check({tag, "/tgt"},    16'(o_tgt),    16'(e.tgt));
        check({tag, "/wr_en"},  16'(o_wr_en),  16'(e.wr_en));
        check({tag, "/op1"},    o_op1,         e.op1);
        check({tag, "/op2"},    o_op2,         e.op2);
        check({tag, "/imm"},    o_imm,         e.imm);
        check({tag, "/pc"},     o_pc,          e.pc);
        if (wb_wr_en && wb_tgt != 3'd0) rf[wb_tgt] = wb_data;
    endtask

    task automatic clear_producers();
        ex_tgt = 3'd0;  ex_wr_en = 1'b0;  ex_is_ld = 1'b0; ex_result = 16'h0;
        mem_tgt = 3'd0; mem_wr_en = 1'b0; mem_data = 16'h0;
        wb_tgt = 3'd0;  wb_wr_en = 1'b0;  wb_data = 16'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        valid    = 1'b0;
        flush    = 1'b0;
        instr    = 16'h0;
        pc       = 16'h0;
        clear_producers();
        rf[0] = 16'h0000;
        for (int i = 1; i < 8; i++) rf[i] = 16'($urandom);

        @(posedge clk);
        #1;

        // Reset held two cycles with a valid instruction and a staged load-use.
        valid = 1'b1;
        instr = rrr(T_ADD, 3'd2, 3'd1, 3'd1);
        pc    = 16'h0040;
        ex_tgt = 3'd1; ex_wr_en = 1'b1; ex_is_ld = 1'b1;
        step("rst0");
        step("rst1");
        check("rst_valid", 16'(o_valid), 16'h0);
        check("rst_op1", o_op1, 16'h0);
        check("rst_op2", o_op2, 16'h0);
        check("rst_stall", 16'(stall), 16'h0);

        // First capture on the edge after release.
        rst_n = 1'b1;
        clear_producers();
        instr = rrr(T_ADD, 3'd3, 3'd1, 3'd2);
        pc    = 16'h0100;
        step("first");
        check("first_valid", 16'(o_valid), 16'h1);

        // EX beats MEM for the same register.
        ex_tgt = 3'd1;  ex_wr_en = 1'b1;  ex_result = 16'h0011;
        mem_tgt = 3'd1; mem_wr_en = 1'b1; mem_data = 16'h0022;
        pc = 16'h0102;
        step("ex_wins");
        check("ex_wins_op1", o_op1, 16'h0011);
        check("ex_wins_op2", o_op2, rf[2]);

        // Load-use: LW r4 in EX, ADDI r5,r4,-1 in ID.
        clear_producers();
        ex_tgt = 3'd4; ex_wr_en = 1'b1; ex_is_ld = 1'b1; ex_result = 16'h7777;
        instr = rri(T_ADDI, 3'd5, 3'd4, 7'h7F);
        pc    = 16'h0104;
        #1;
        check("lu_stall_hi", 16'(stall), 16'h1);
        step("lu_stall");
        check("lu_bubble", 16'(o_valid), 16'h0);
        ex_wr_en = 1'b0; ex_is_ld = 1'b0; ex_tgt = 3'd0;
        mem_tgt = 3'd4; mem_wr_en = 1'b1; mem_data = 16'h5A5A;
        step("lu_retry");
        check("lu_stall_lo", 16'(stall), 16'h0);
        check("lu_op1", o_op1, 16'h5A5A);
        check("lu_imm", o_imm, 16'hFFFF);
        check("lu_valid", 16'(o_valid), 16'h1);

        // WB write of r2 in the same cycle ADD reads it.
        clear_producers();
        rf[2] = 16'h1111;
        wb_tgt = 3'd2; wb_wr_en = 1'b1; wb_data = 16'hBEEF;
        instr = rrr(T_ADD, 3'd1, 3'd3, 3'd2);
        pc    = 16'h0106;
        step("wb_bypass");
        check("wb_op2", o_op2, 16'hBEEF);
        clear_producers();

        // Load-use and flush together: flush wins, no stall.
        ex_tgt = 3'd1; ex_wr_en = 1'b1; ex_is_ld = 1'b1;
        instr = rrr(T_ADD, 3'd2, 3'd1, 3'd3);
        flush = 1'b1;
        step("flush_lu");
        check("flush_valid", 16'(o_valid), 16'h0);
        check("flush_stall", 16'(stall), 16'h0);
        flush = 1'b0;
        clear_producers();

        // Destination r0 never writes.
        instr = rrr(T_ADD, 3'd0, 3'd1, 3'd2);
        step("tgt_r0");
        check("r0_wr_en", 16'(o_wr_en), 16'h0);
        check("r0_cap_valid", 16'(o_valid), 16'h1);

        // Source r0 reads 0 even with an EX producer targeting r0.
        ex_tgt = 3'd0; ex_wr_en = 1'b1; ex_result = 16'h1234;
        instr = rri(T_ADDI, 3'd3, 3'd0, 7'd5);
        step("src_r0");
        check("src_r0_op1", o_op1, 16'h0000);
        clear_producers();

        // LUI immediate, BEQ read ports, SW store data.
        instr = {T_LUI, 3'd1, 10'h3FF};
        step("lui");
        check("lui_imm", o_imm, 16'hFFC0);
        instr = rri(T_BEQ, 3'd2, 3'd3, 7'd0);
        step("beq");
        check("beq_src1", 16'(src1), 16'h2);
        check("beq_src2", 16'(src2), 16'h3);
        instr = rri(T_SW, 3'd6, 3'd7, 7'd1);
        step("sw");
        check("sw_op2", o_op2, rf[6]);

        // Randomized traffic, rarely resetting, biased towards hazards.
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 31) != 0);
            valid     = ($urandom_range(0, 4) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            instr     = 16'($urandom);
            if ($urandom_range(0, 3) == 0) instr[15:13] = T_LW;
            pc        = 16'($urandom);
            ex_tgt    = 3'($urandom_range(0, 7));
            ex_wr_en  = 1'($urandom);
            ex_is_ld  = ($urandom_range(0, 2) == 0);
            ex_result = 16'($urandom);
            mem_tgt   = 3'($urandom_range(0, 7));
            mem_wr_en = 1'($urandom);
            mem_data  = 16'($urandom);
            wb_tgt    = 3'($urandom_range(0, 7));
            wb_wr_en  = 1'($urandom);
            wb_data   = 16'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
